// File: rtl/ex_mem_pkg.sv
// Shared types for the execute-to-memory pipeline register.
// Payload is sized for the widest datapath; narrower builds leave upper bits zero.
package ex_mem_pkg;

    localparam int RD_W     = 5;
    localparam int XLEN_MAX = 64;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } mem_op_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0] result;
        logic [XLEN_MAX-1:0] store_data;
        logic [RD_W-1:0]     rd;
        logic                reg_write;
        mem_op_t             mem_op;
        logic [2:0]          funct3;
    } ex_mem_t;

    // The unused encoding 2'b11 is treated as "no memory access".
    function automatic mem_op_t sanitize_mem_op(input logic [1:0] raw);
        mem_op_t op;
        case (raw)
            2'd1:    op = LOAD;
            2'd2:    op = STORE;
            default: op = NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready skid buffer carrying an opaque payload, with flush.
// Latency: 1 cycle from accept to out_vld.
// Backpressure: in_rdy is registered (!skid valid); no combinational path from out_rdy.
module skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] main_dat_q, main_dat_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             push;
    logic             pop;

    assign push = in_vld && !skid_vld_q && !flush;
    assign pop  = main_vld_q && out_rdy;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_dat_d = main_dat_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q) begin
            if (push) begin
                main_vld_d = 1'b1;
                main_dat_d = in_dat;
            end
        end else if (!skid_vld_q) begin
            if (push && pop) begin
                main_dat_d = in_dat;
            end else if (push) begin
                skid_vld_d = 1'b1;
                skid_dat_d = in_dat;
            end else if (pop) begin
                main_vld_d = 1'b0;
            end
        end else if (pop) begin
            // Skid always drains into main so ordering stays strictly FIFO.
            main_dat_d = skid_dat_q;
            skid_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_dat_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
        end
    end

    assign in_rdy  = !skid_vld_q;
    assign out_vld = main_vld_q;
    assign out_dat = main_dat_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register: two-entry skid buffer plus head-entry forwarding tap.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready drops only once the skid entry fills; it never depends on out_ready.
module ex_mem_skid
    import ex_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic [1:0]        in_mem_op,
    input  logic [2:0]        in_funct3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_store_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write,
    output logic [1:0]        out_mem_op,
    output logic [2:0]        out_funct3,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [XLEN-1:0]   fwd_data
);

    ex_mem_t in_ent;
    ex_mem_t out_ent;

    always_comb begin
        in_ent                       = '0;
        in_ent.result[XLEN-1:0]      = in_result;
        in_ent.store_data[XLEN-1:0]  = in_store_data;
        in_ent.rd                    = in_rd;
        in_ent.reg_write             = in_reg_write;
        in_ent.mem_op                = sanitize_mem_op(in_mem_op);
        in_ent.funct3                = in_funct3;
    end

    skid_buf #(
        .WIDTH ($bits(ex_mem_t))
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  (in_ent),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (out_ent)
    );

    assign out_result     = out_ent.result[XLEN-1:0];
    assign out_store_data = out_ent.store_data[XLEN-1:0];
    assign out_rd         = out_ent.rd;
    assign out_reg_write  = out_ent.reg_write;
    assign out_mem_op     = out_ent.mem_op;
    assign out_funct3     = out_ent.funct3;

    // Loads have no data yet at this stage, and x0 is never a real producer.
    assign fwd_valid = out_valid && out_ent.reg_write && (out_ent.rd != '0)
                       && (out_ent.mem_op != LOAD);
    assign fwd_rd    = out_ent.rd;
    assign fwd_data  = out_ent.result[XLEN-1:0];

    if (XLEN < XLEN_MAX) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{out_ent.result[XLEN_MAX-1:XLEN],
                             out_ent.store_data[XLEN_MAX-1:XLEN]};
    end

endmodule

// File: tb/tb_ex_mem_skid.sv
module tb_ex_mem_skid;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_result = '0;
    logic [XLEN-1:0] in_store_data = '0;
    logic [4:0]      in_rd = '0;
    logic            in_reg_write = 1'b0;
    logic [1:0]      in_mem_op = '0;
    logic [2:0]      in_funct3 = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_store_data;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic [1:0]      out_mem_op;
    logic [2:0]      out_funct3;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;

    always #5 clk = ~clk;

    ex_mem_skid #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_mem_op      (in_mem_op),
        .in_funct3      (in_funct3),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_op     (out_mem_op),
        .out_funct3     (out_funct3),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
    );

    typedef struct {
        logic [63:0] result;
        logic [63:0] store_data;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  op;
        logic [2:0]  f3;
    } beat_t;

    // Reference model: the in-flight beats in arrival order, at most two.
    beat_t q[$];
    beat_t acc_beat;
    bit    acc_pend = 1'b0;
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [63:0] res, input logic [4:0] rd,
                                 input logic rw, input logic [1:0] op, input logic [2:0] f3);
        beat_t b;
        b.result     = res;
        b.store_data = {$urandom(), $urandom()};
        b.rd         = rd;
        b.rw         = rw;
        b.op         = op;
        b.f3         = f3;
        return b;
    endfunction

    // One cycle of stimulus; first commits the beat accepted at the edge just passed.
    task automatic step(input bit v, input beat_t b, input bit ordy, input bit fl, input bit rst);
        @(posedge clk);
        #1;
        if (acc_pend) q.push_back(acc_beat);
        in_valid      = v;
        in_result     = b.result;
        in_store_data = b.store_data;
        in_rd         = b.rd;
        in_reg_write  = b.rw;
        in_mem_op     = b.op;
        in_funct3     = b.f3;
        out_ready     = ordy;
        flush         = fl;
        reset         = rst;
        acc_pend      = v && !fl && !rst && (q.size() < 2);
        acc_beat      = b;
        if (b.op == 2'b11) acc_beat.op = 2'b00;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, mk(64'h0, 5'd0, 1'b0, 2'd0, 3'd0), ordy, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " in_ready"}, in_ready, 1);
        chk({tag, " fwd_valid"}, fwd_valid, 0);
        chk({tag, " out_result"}, out_result, 0);
        chk({tag, " out_store_data"}, out_store_data, 0);
        chk({tag, " out_rd"}, out_rd, 0);
        chk({tag, " out_reg_write"}, out_reg_write, 0);
        chk({tag, " out_mem_op"}, out_mem_op, 0);
        chk({tag, " out_funct3"}, out_funct3, 0);
        chk({tag, " fwd_data"}, fwd_data, 0);
    endtask

    // Monitor: compares DUT outputs against the model head mid-cycle, then retires.
    always @(negedge clk) begin : monitor
        beat_t h;
        if (!reset) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            if (q.size() > 0) begin
                h = q[0];
                chk("out_result", out_result, h.result);
                chk("out_store_data", out_store_data, h.store_data);
                chk("out_rd", out_rd, h.rd);
                chk("out_reg_write", out_reg_write, h.rw);
                chk("out_mem_op", out_mem_op, h.op);
                chk("out_funct3", out_funct3, h.f3);
                chk("fwd_valid", fwd_valid, h.rw && (h.rd != 0) && (h.op != 2'd1));
                chk("fwd_rd", fwd_rd, h.rd);
                chk("fwd_data", fwd_data, h.result);
            end else begin
                chk("fwd_valid empty", fwd_valid, 0);
            end
        end
        if (reset || flush) q.delete();
        else if (q.size() > 0 && out_ready) void'(q.pop_front());
    end

    initial begin
        int tries;
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1);
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk_zero("reset");

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++)
            step(1'b1, mk(64'(i * 16), 5'(i), 1'b1, 2'd0, 3'd2), 1'b1, 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // Backpressure: fill both entries, hold the third beat off.
        step(1'b1, mk(64'h10, 5'd1, 1'b1, 2'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(64'h20, 5'd2, 1'b1, 2'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(64'h30, 5'd3, 1'b1, 2'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        chk("full in_ready", in_ready, 0);
        chk("full head", out_result, 64'h10);
        tries = 0;
        do begin
            step(1'b1, mk(64'h30, 5'd3, 1'b1, 2'd0, 3'd0), 1'b1, 1'b0, 1'b0);
            tries++;
        end while (!acc_pend && tries < 10);
        chk("third beat accepted", acc_pend, 1);
        repeat (4) idle(1'b1);

        // Flush while full with a beat offered.
        step(1'b1, mk(64'h41, 5'd1, 1'b1, 2'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(64'h42, 5'd2, 1'b1, 2'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(64'h99, 5'd9, 1'b1, 2'd0, 3'd0), 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        repeat (2) idle(1'b1);

        // Simultaneous accept and pop with one entry held.
        step(1'b1, mk(64'hAA, 5'd7, 1'b1, 2'd0, 3'd0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(64'hBB, 5'd8, 1'b1, 2'd0, 3'd0), 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("acc+pop result", out_result, 64'hBB);
        chk("acc+pop in_ready", in_ready, 1);
        idle(1'b1);

        // Forwarding mask cases, plus the 2'b11 encoding and a wide result.
        step(1'b1, mk(64'h111, 5'd0, 1'b1, 2'd0, 3'd0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(64'h222, 5'd5, 1'b1, 2'd1, 3'd0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(64'h333, 5'd5, 1'b1, 2'd0, 3'd0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(64'h444, 5'd6, 1'b1, 2'd3, 3'd1), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(64'hFFFFFFFF_80000000, 5'd9, 1'b1, 2'd0, 3'd0), 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("wide result", out_result, 64'hFFFFFFFF_80000000);
        chk("wide fwd_data", fwd_data, 64'hFFFFFFFF_80000000);
        idle(1'b1);

        // Reset mid-stream while full.
        step(1'b1, mk(64'h51, 5'd1, 1'b1, 2'd2, 3'd3), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(64'h52, 5'd2, 1'b1, 2'd2, 3'd3), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(64'h53, 5'd3, 1'b1, 2'd0, 3'd0), 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk_zero("mid reset");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0,
                 mk({$urandom(), $urandom()}, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7))),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 199) == 0);
        end
        repeat (5) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
# ex_mem_skid

Two-entry skid pipeline register between the execute stage and the memory stage of the Dragon core. It captures the ALU result together with destination and memory-control fields, and decouples execute from memory stalls with a valid/ready handshake. It also exposes the oldest in-flight result to the hazard unit for EX→EX forwarding.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill all held entries and the input beat this cycle.
- in_valid  in  1  execute stage offers a beat.
- in_ready  out  1  block can accept a beat.
- in_result  in  XLEN  ALU `y`, already word-sign-extended by the ALU.
- in_store_data  in  XLEN  rs2 value for stores.
- in_rd  in  5  destination register.
- in_reg_write  in  1  writes rd.
- in_mem_op  in  2  mem_op_t: NONE, LOAD, STORE.
- in_funct3  in  3  access size/sign.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts head.
- out_result, out_store_data, out_rd, out_reg_write, out_mem_op, out_funct3  out  (as inputs)  head entry payload.
- fwd_valid  out  1  head valid, reg_write=1, rd≠0, mem_op≠LOAD.
- fwd_rd  out  5  head rd.
- fwd_data  out  XLEN  head result.

## Operation
- Storage: main entry (head) and skid entry, each with a valid bit and a payload. States: EMPTY (none valid), ONE (main only), FULL (both).
- in_ready = !skid_valid. It is a pure register output with no combinational path from out_ready.
- Accept when in_valid && in_ready && !flush. Pop when out_valid && out_ready.
- EMPTY: accept → ONE, with the payload loaded into main.
- ONE:
  - accept & pop → ONE, main ← input.
  - accept only → FULL, skid ← input.
  - pop only → EMPTY.
  - neither → hold.
- FULL: in_ready=0.
  - pop → ONE, main ← skid, skid invalid.
  - no pop → hold.
- Ordering is strict FIFO. The skid entry never overtakes main.
- flush: both valid bits clear at the next edge, and the input beat is dropped. Flush takes priority over accept and pop in the same cycle. Payload registers may keep stale data.
- reset: same as flush, and additionally zeroes all payload registers.
- Outputs come directly from the main entry. Payload outputs are don't-care when out_valid=0, but the bench sees zeros after reset.
- in_mem_op value 2'b11: the entry is stored as NONE.
- No arithmetic is performed. Widths pass through unchanged.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on out_* after edge N.
- Throughput is 1 beat/cycle while out_ready=1.
- out_ready deasserted for one cycle: one beat is absorbed into skid and in_ready drops the next cycle. in_ready returns 1 the cycle after the first pop from FULL.
- in_valid may deassert without having been accepted. Payload is sampled only on accept.
- Reset values: out_valid=0, in_ready=1, fwd_valid=0, all payload outputs 0.
- Reset or flush asserted mid-stall while FULL: the block is EMPTY the next cycle and in_ready=1.

## Structure
- Package ex_mem_pkg:
  - mem_op_t enum (NONE=0, LOAD=1, STORE=2).
  - ex_mem_t packed struct {result, store_data, rd, reg_write, mem_op, funct3}.
  - Localparam for the rd width (5).
- Sub-module skid_buf #(WIDTH): a generic 2-entry valid/ready skid buffer carrying an opaque WIDTH-bit payload with flush.
  - ex_mem_skid instantiates it with $bits(ex_mem_t).
  - ex_mem_skid adds mem_op sanitizing and the fwd_* logic.

## Test plan
- Reset, then stream 4 beats (result=0x10,0x20,0x30,0x40, rd=1..4) with out_ready=1 → out_valid each following cycle in order, in_ready held at 1.
- Backpressure: send 3 beats with out_ready=0 → first two held (FULL), in_ready=0 after second, third held off. Raise out_ready → 0x10, 0x20, 0x30 emerge in order with no loss or duplication.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1. The dropped input never appears.
- Simultaneous accept+pop in ONE state: main=0xAA, input 0xBB, out_ready=1 → next cycle out_result=0xBB, state ONE.
- Forwarding mask:
  - rd=0, reg_write=1 → fwd_valid=0.
  - LOAD with rd=5 → fwd_valid=0.
  - ALU op with rd=5 → fwd_valid=1, fwd_data=result.
- XLEN=64: result 0xFFFFFFFF_80000000 passes unchanged. Reset asserted mid-stream → all outputs 0 next cycle.
